// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC  = 8'h00;
  localparam logic [DATA_W-1:0] HALT_WORD = 16'h9800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pipe_reg.sv
// Holding register between the ROM and decode: instruction word, its address
// and a valid flag. Flush wins over load; with neither, the contents hold.
module fetch_pipe_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;

  // Capture, flush or hold the word presented to decode.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of block ordering.
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the combinational ROM,
// and hands registered words to decode over a valid/ready handshake.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  fetch_state_t      r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic              r_halted, w_halted_next;

  logic              w_load, w_flush;
  logic              w_valid;
  logic              w_start_take;
  logic              w_redirect_take;
  logic              w_advance;
  logic              w_accept;

  // Start restarts from IDLE or HALT; redirect acts in FETCH/HALT until halted.
  assign w_start_take    = start && (r_state != FETCH);
  assign w_redirect_take = redirect_valid && (r_state != IDLE) && !r_halted
                           && !w_start_take;
  assign w_advance       = !w_valid || instr_ready;
  assign w_accept        = w_valid && instr_ready && !w_redirect_take;

  // Next-state, PC and pipe-register control.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_next_state  = r_state;
    w_pc_next     = r_pc;
    w_halted_next = r_halted;
    w_load        = 1'b0;
    w_flush       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_start_take) begin
          w_next_state  = FETCH;
          w_pc_next     = RESET_PC;
          w_halted_next = 1'b0;
          w_flush       = 1'b1;
        end
      end

      FETCH: begin
        if (w_redirect_take) begin
          w_pc_next = redirect_pc;
          w_flush   = 1'b1;
        end else if (w_advance) begin
          w_load    = 1'b1;
          w_pc_next = r_pc + 1'b1;  // wraps modulo 2^ADDR_W
          if (rom_data == HALT_WORD) w_next_state = HALT;
        end
      end

      HALT: begin
        if (w_start_take) begin
          w_next_state  = FETCH;
          w_pc_next     = RESET_PC;
          w_halted_next = 1'b0;
          w_flush       = 1'b1;
        end else if (w_redirect_take) begin
          w_next_state = FETCH;
          w_pc_next    = redirect_pc;
          w_flush      = 1'b1;
        end else if (w_valid && instr_ready) begin
          // Decode took the halt word: fetch is now fully stopped.
          w_halted_next = 1'b1;
          w_flush       = 1'b1;
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  // State, PC and halted flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pc     <= w_pc_next;
      r_halted <= w_halted_next;
    end
  end

  fetch_pipe_reg u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (rom_data),
    .i_pc    (r_pc),
    .o_instr (instr),
    .o_pc    (instr_pc),
    .o_valid (w_valid)
  );

  assign rom_address = r_pc;
  assign instr_valid = w_valid;
  assign halted      = r_halted;
  assign busy        = (r_state == FETCH);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_count;
  logic        w_stall;

  assign w_stall = w_valid && !instr_ready;

  // Saturating performance counters, cleared whenever fetch restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else if (w_start_take) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_accept && (r_fetch_count != 16'hFFFF)) r_fetch_count <= r_fetch_count + 1'b1;
      if (w_stall  && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`else
  // Accept strobe only feeds the optional counters.
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle vector table for the
// fetch/stall/redirect stream, scoreboard of accepted words, and hand-written
// halt, wrap, restart and asynchronous-reset sequences.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  logic              busy;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       fetch_count;
  logic [15:0]       stall_count;
`endif

  logic [DATA_W-1:0] rom [256];
  assign rom_data = rom[rom_address];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .busy           (busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  typedef struct {
    logic        ready;
    logic        redir;
    logic [7:0]  rpc;
    int          push_n;
    logic        exp_valid;
    logic [7:0]  exp_ipc;
    logic [15:0] exp_instr;
    logic [7:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ready, input logic redir, input logic [7:0] rpc,
                              input int push_n, input logic ev, input logic [7:0] eipc,
                              input logic [15:0] einstr, input logic [7:0] eaddr);
    vec_t v;
    v.ready = ready;  v.redir = redir;  v.rpc = rpc;  v.push_n = push_n;
    v.exp_valid = ev; v.exp_ipc = eipc; v.exp_instr = einstr; v.exp_addr = eaddr;
    return v;
  endfunction

  // Expect n words from consecutive addresses to be accepted in order.
  task automatic push_run(input logic [7:0] first, input int n);
    logic [7:0] a;
    sb_t e;
    a = first;
    for (int i = 0; i < n; i++) begin
      e.pc = a;
      e.word = rom[a];
      sb.push_back(e);
      a = a + 8'd1;
    end
  endtask

  // One clock: note any handshake completing at this edge, then sample #1 after it.
  task automatic step();
    logic        acc;
    logic [7:0]  apc;
    logic [15:0] aw;
    sb_t         e;
    acc = instr_valid && instr_ready && !redirect_valid;
    if (instr_valid && !instr_ready) n_stall++;
    apc = instr_pc;
    aw  = instr;
    @(posedge clk);
    #1;
    if (acc) begin
      n_acc++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got word at %h, none expected", apc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", 32'(apc), 32'(e.pc));
        check("sb_instr", 32'(aw), 32'(e.word));
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [7:0] eaddr,
                               input logic eh, input logic eb);
    check({tag, "_valid"},  32'(instr_valid), 32'(ev));
    check({tag, "_addr"},   32'(rom_address), 32'(eaddr));
    check({tag, "_halted"}, 32'(halted),      32'(eh));
    check({tag, "_busy"},   32'(busy),        32'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = {8'h12, 8'(a)};
    for (int a = 0; a < 16; a++) rom[a] = 16'hC000 + 16'(a) * 16'h0800 + 16'(a);
    rom[8'h0A] = 16'hC001;
    rom[8'hFE] = 16'h0000;
    rom[8'hFF] = 16'h9800;

    reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    check_outputs("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_instr", 32'(instr), 32'h0);
    check("reset_ipc", 32'(instr_pc), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    check_outputs("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Start: FETCH after this edge, first word valid one edge later.
    start = 1'b1; instr_ready = 1'b1;
    push_run(8'h00, 7);
    step();
    start = 1'b0;
    check_outputs("start", 1'b0, 8'h00, 1'b0, 1'b1);

    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 16'hC000, 8'h01));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 16'hC801, 8'h02));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 16'hD002, 8'h03));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h03, 16'hD803, 8'h04));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h04, 16'hE004, 8'h05));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h05, 16'hE805, 8'h06));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h05, 16'hE805, 8'h06));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h05, 16'hE805, 8'h06));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h05, 16'hE805, 8'h06));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h06, 16'hF006, 8'h07));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h07, 16'hF807, 8'h08));
    vecs.push_back(mk(1, 1, 8'h03, 0, 0, 8'h00, 16'h0000, 8'h03));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h03, 16'hD803, 8'h04));
    vecs.push_back(mk(1, 1, 8'h0A, 1, 0, 8'h00, 16'h0000, 8'h0A));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h0A, 16'hC001, 8'h0B));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h0B, 16'h180B, 8'h0C));
    vecs.push_back(mk(1, 1, 8'hFE, 2, 0, 8'h00, 16'h0000, 8'hFE));

    foreach (vecs[i]) begin
      instr_ready    = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      if (vecs[i].redir) push_run(vecs[i].rpc, vecs[i].push_n);
      step();
      redirect_valid = 1'b0;
      check($sformatf("r%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("r%0d_addr", i),  32'(rom_address), 32'(vecs[i].exp_addr));
      check($sformatf("r%0d_busy", i),  32'(busy), 32'h1);
      if (vecs[i].exp_valid) begin
        check($sformatf("r%0d_ipc", i),   32'(instr_pc), 32'(vecs[i].exp_ipc));
        check($sformatf("r%0d_instr", i), 32'(instr),    32'(vecs[i].exp_instr));
      end
    end

    // Halt word at FF: presented normally, PC wraps to 00, state goes HALT.
    instr_ready = 1'b1;
    step();
    check_outputs("fe", 1'b1, 8'hFF, 1'b0, 1'b1);
    check("fe_ipc", 32'(instr_pc), 32'hFE);
    check("fe_instr", 32'(instr), 32'h0000);
    step();
    check_outputs("ff", 1'b1, 8'h00, 1'b0, 1'b0);
    check("ff_ipc", 32'(instr_pc), 32'hFF);
    check("ff_instr", 32'(instr), 32'h9800);
    instr_ready = 1'b0;
    step();
    check_outputs("halt_stall", 1'b1, 8'h00, 1'b0, 1'b0);
    instr_ready = 1'b1;
    step();
    check_outputs("halted", 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", 32'(fetch_count), 32'(n_acc));
    check("perf_stall", 32'(stall_count), 32'(n_stall));
    check("perf_fetch10", 32'(fetch_count), 32'd10);
    check("perf_stall4", 32'(stall_count), 32'd4);
`endif
    step();
    step();
    check_outputs("halted_idle", 1'b0, 8'h00, 1'b1, 1'b0);

    // Redirect once halted is ignored.
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    step();
    redirect_valid = 1'b0;
    check_outputs("halt_redir", 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check_outputs("halt_redir2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Start from HALT restarts at RESET_PC.
    start = 1'b1;
    step();
    start = 1'b0;
    n_acc = 0; n_stall = 0;
    push_run(8'h00, 1);
    check_outputs("restart", 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_clr_fetch", 32'(fetch_count), 32'd0);
    check("perf_clr_stall", 32'(stall_count), 32'd0);
`endif
    step();
    check_outputs("restart_w0", 1'b1, 8'h01, 1'b0, 1'b1);
    check("restart_instr", 32'(instr), 32'hC000);
    step();
    check("restart_ipc1", 32'(instr_pc), 32'h01);
    instr_ready = 1'b0;
    step();
    check_outputs("pre_reset", 1'b1, 8'h02, 1'b0, 1'b1);

    // Asynchronous reset between edges while a word is stalled.
    #3;
    reset = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    check("async_rst_instr", 32'(instr), 32'h0);
    check("async_rst_ipc", 32'(instr_pc), 32'h0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    instr_ready = 1'b1;
    step();
    step();
    step();
    check_outputs("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
